uart_rx_pkt_reader: RTL and testbench
=====================================

Name: uart_rx_pkt_reader

Overview:
Drains the uart RX FIFO and parses framed register-write packets from the host link: sync, address, length, payload, checksum. It buffers the payload and commits it to the LED-matrix register bus only after the checksum passes, so a corrupted frame never writes registers. It is the read-side counterpart of the TX FIFO drain FSM and sits between the uart block and the matrix control registers.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (buffer depth, 1..255).
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CLKS, 115200, inter-byte timeout in CLK cycles inside a frame (counter width = clog2(TIMEOUT_CLKS+1)).

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous, active-high reset.
RX_FIFO_EMPTY  in  1  RX FIFO empty flag.
RX_FIFO_Q  in  8  RX FIFO read data (non-showahead: valid the cycle after the read request).
RX_FIFO_RD_REQ  out  1  one-cycle FIFO read strobe, registered.
REG_WR_STB  out  1  register write strobe, one cycle per byte.
REG_ADDR  out  8  register address for REG_WR_STB.
REG_DATA  out  8  register data for REG_WR_STB.
PKT_OK  out  1  one-cycle pulse, frame committed.
PKT_ERR  out  1  one-cycle pulse, frame dropped.
ERR_CODE  out  2  cause of last PKT_ERR: 1 bad length, 2 checksum, 3 timeout; holds until next PKT_ERR.
BUSY  out  1  high while field != SYNC or while in COMMIT.

Behaviour:
- Reset: all outputs 0, state IDLE, field SYNC, buffer contents don't-care, timeout counter 0.
- Fetch FSM, all outputs registered:
  - IDLE: if !RX_FIFO_EMPTY, go to FETCH.
  - FETCH: RX_FIFO_RD_REQ=1 for exactly this cycle, then go to WAIT.
  - WAIT: RD_REQ=0; FIFO presents data; go to LATCH.
  - LATCH: sample RX_FIFO_Q, process it per the current field, then return to IDLE, or go to COMMIT.
  - Minimum 4 cycles per byte. No second RD_REQ is issued until LATCH completes, so the FIFO is never over-read.
- Field handling in LATCH:
  - SYNC: byte==SYNC_BYTE goes to ADDR; any other byte is discarded silently with no PKT_ERR.
  - ADDR: store base address; sum=byte; go to LEN.
  - LEN: if 0 or >MAX_LEN, PKT_ERR with code 1 and return to SYNC. Otherwise store len, sum+=byte, idx=0, go to DATA.
  - DATA: buf[idx]=byte; sum+=byte; idx++; when idx==len go to CHK.
  - CHK: if byte==sum[7:0], go to COMMIT with field SYNC. Otherwise PKT_ERR with code 2 and return to SYNC.
- Checksum is the 8-bit modulo-256 sum of ADDR, LEN and payload bytes.
- A SYNC_BYTE value inside ADDR/LEN/DATA/CHK is treated as data; there is no resync mid-frame.
- COMMIT:
  - For i=0..len-1 on consecutive cycles: REG_WR_STB=1, REG_ADDR=(base+i) mod 256, REG_DATA=buf[i].
  - The cycle after the last write: REG_WR_STB=0, PKT_OK=1, then go to IDLE.
  - No FIFO reads during COMMIT; incoming bytes accumulate in the FIFO.
- Timeout:
  - The counter increments each cycle in IDLE while field != SYNC and the FIFO is empty; it clears on every FETCH.
  - When it reaches TIMEOUT_CLKS: PKT_ERR with code 3, field goes to SYNC, counter clears.
  - No timeout in the SYNC field.
- REG_ADDR/REG_DATA are meaningful only while REG_WR_STB=1; they hold their last value otherwise.
- PKT_OK and PKT_ERR never assert in the same cycle.
- RESET mid-frame or mid-COMMIT aborts immediately with no further writes and no PKT_ERR; already-fetched FIFO bytes are lost.

Test Plan:
- Valid frame: FIFO bytes A5 10 02 11 22 45 -> writes (10,11) then (11,22) on consecutive cycles, then PKT_OK; ERR_CODE stays 0; exactly 6 RD_REQ pulses.
- Junk before frame: 00 FF 5A A5 20 01 7E 9F -> junk dropped with no PKT_ERR; single write (20,7E); PKT_OK.
- Bad checksum: A5 10 01 33 00 -> no REG_WR_STB; PKT_ERR with ERR_CODE=2. A following valid frame still commits.
- Bad length: A5 10 00, and separately A5 10 11 with MAX_LEN=16 -> PKT_ERR with ERR_CODE=1; the next bytes are hunted for sync.
- Timeout and wrap: A5 FE, then 200 cycles empty with TIMEOUT_CLKS=100 -> PKT_ERR, ERR_CODE=3 at cycle 100. Then A5 FF 02 01 02 04 -> writes (FF,01), (00,02).
- Reset mid-COMMIT: assert RESET during the second write of a 4-byte frame -> all outputs 0 next cycle, no further writes; a subsequent frame is accepted normally.

Source files
------------

// File: rtl/uart_rx_pkt_reader.sv
// Drains the UART RX FIFO, parses sync/addr/len/payload/checksum frames and
// replays the buffered payload onto the register bus only when the checksum matches.
module uart_rx_pkt_reader #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX_FIFO_EMPTY,
    input  logic [7:0] RX_FIFO_Q,
    output logic       RX_FIFO_RD_REQ,
    output logic       REG_WR_STB,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_DATA,
    output logic       PKT_OK,
    output logic       PKT_ERR,
    output logic [1:0] ERR_CODE,
    output logic       BUSY
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LATCH, S_COMMIT} state_t;
    typedef enum logic [2:0] {F_SYNC, F_ADDR, F_LEN, F_DATA, F_CHK} field_t;

    state_t        state;
    field_t        field;
    logic [7:0]    base;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [7:0]    sum;
    logic [TW-1:0] tcnt;
    logic [7:0]    pbuf [MAX_LEN];

    assign BUSY = (field != F_SYNC) || (state == S_COMMIT);

    // Payload buffer holds only data, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (state == S_LATCH && field == F_DATA)
            pbuf[idx[IW-1:0]] <= RX_FIFO_Q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= S_IDLE;
            field          <= F_SYNC;
            base           <= '0;
            len            <= '0;
            idx            <= '0;
            sum            <= '0;
            tcnt           <= '0;
            RX_FIFO_RD_REQ <= 1'b0;
            REG_WR_STB     <= 1'b0;
            REG_ADDR       <= '0;
            REG_DATA       <= '0;
            PKT_OK         <= 1'b0;
            PKT_ERR        <= 1'b0;
            ERR_CODE       <= '0;
        end else begin
            RX_FIFO_RD_REQ <= 1'b0;
            REG_WR_STB     <= 1'b0;
            PKT_OK         <= 1'b0;
            PKT_ERR        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!RX_FIFO_EMPTY) begin
                        state          <= S_FETCH;
                        RX_FIFO_RD_REQ <= 1'b1;
                        tcnt           <= '0;
                    end else if (field != F_SYNC) begin
                        // Inter-byte timeout only runs inside a frame.
                        if (tcnt == TW'(TIMEOUT_CLKS - 1)) begin
                            PKT_ERR  <= 1'b1;
                            ERR_CODE <= 2'd3;
                            field    <= F_SYNC;
                            tcnt     <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_LATCH;
                S_LATCH: begin
                    state <= S_IDLE;
                    case (field)
                        F_SYNC: begin
                            if (RX_FIFO_Q == SYNC_BYTE)
                                field <= F_ADDR;
                        end
                        F_ADDR: begin
                            base  <= RX_FIFO_Q;
                            sum   <= RX_FIFO_Q;
                            field <= F_LEN;
                        end
                        F_LEN: begin
                            if (RX_FIFO_Q == 8'd0 || RX_FIFO_Q > 8'(MAX_LEN)) begin
                                PKT_ERR  <= 1'b1;
                                ERR_CODE <= 2'd1;
                                field    <= F_SYNC;
                            end else begin
                                len   <= RX_FIFO_Q;
                                sum   <= sum + RX_FIFO_Q;
                                idx   <= '0;
                                field <= F_DATA;
                            end
                        end
                        F_DATA: begin
                            sum <= sum + RX_FIFO_Q;
                            idx <= idx + 8'd1;
                            if (idx + 8'd1 == len)
                                field <= F_CHK;
                        end
                        F_CHK: begin
                            field <= F_SYNC;
                            if (RX_FIFO_Q == sum) begin
                                state <= S_COMMIT;
                                idx   <= '0;
                            end else begin
                                PKT_ERR  <= 1'b1;
                                ERR_CODE <= 2'd2;
                            end
                        end
                        default: field <= F_SYNC;
                    endcase
                end
                S_COMMIT: begin
                    // idx is reused as the replay pointer; FIFO reads pause here.
                    if (idx != len) begin
                        REG_WR_STB <= 1'b1;
                        REG_ADDR   <= base + idx;
                        REG_DATA   <= pbuf[idx[IW-1:0]];
                        idx        <= idx + 8'd1;
                    end else begin
                        PKT_OK <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_reader.sv
// Scoreboard bench for uart_rx_pkt_reader: a frame-level reference model queues
// expected bus writes / OK / ERR events, and an independent monitor pops them.
module tb_uart_rx_pkt_reader;

    localparam int MAX_LEN = 16;
    localparam int TO      = 100;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX_FIFO_EMPTY = 1'b1;
    logic [7:0] RX_FIFO_Q = 8'h00;
    logic       RX_FIFO_RD_REQ;
    logic       REG_WR_STB;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_DATA;
    logic       PKT_OK;
    logic       PKT_ERR;
    logic [1:0] ERR_CODE;
    logic       BUSY;

    uart_rx_pkt_reader #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
        .CLK(CLK), .RESET(RESET), .RX_FIFO_EMPTY(RX_FIFO_EMPTY), .RX_FIFO_Q(RX_FIFO_Q),
        .RX_FIFO_RD_REQ(RX_FIFO_RD_REQ), .REG_WR_STB(REG_WR_STB), .REG_ADDR(REG_ADDR),
        .REG_DATA(REG_DATA), .PKT_OK(PKT_OK), .PKT_ERR(PKT_ERR), .ERR_CODE(ERR_CODE),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;   // 0 write, 1 ok, 2 err
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    int checks = 0, errors = 0;
    int cyc = 0, last_rd_cyc = 0, rd_count = 0, overread = 0, pushed = 0;
    logic rd_prev = 1'b0;

    // Reference model state: which field of the frame comes next
    int         m_field = 0;
    int         m_base = 0, m_len = 0;
    logic [7:0] m_pl[$];

    // Non-showahead FIFO model: data appears the cycle after the read strobe
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RX_FIFO_RD_REQ) begin
            rd_count    <= rd_count + 1;
            last_rd_cyc <= cyc;
            if (fifo.size() == 0) overread <= overread + 1;
            else RX_FIFO_Q <= fifo.pop_front();
        end
        RX_FIFO_EMPTY <= (fifo.size() == 0);
    end

    function automatic void push_ev(input int kind, input int a, input int d);
        ev_t e;
        e.kind = kind;
        e.a = 8'(a);
        e.d = 8'(d);
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int s;
        case (m_field)
            0: if (b == 8'hA5) m_field = 1;
            1: begin m_base = int'(b); m_field = 2; end
            2: begin
                if (b == 0 || int'(b) > MAX_LEN) begin
                    push_ev(2, 0, 1);
                    m_field = 0;
                end else begin
                    m_len = int'(b);
                    m_pl.delete();
                    m_field = 3;
                end
            end
            3: begin
                m_pl.push_back(b);
                if (m_pl.size() == m_len) m_field = 4;
            end
            default: begin
                s = m_base + m_len;
                foreach (m_pl[i]) s += int'(m_pl[i]);
                if (int'(b) == s % 256) begin
                    foreach (m_pl[i]) push_ev(0, (m_base + i) % 256, int'(m_pl[i]));
                    push_ev(1, 0, 0);
                end else begin
                    push_ev(2, 0, 2);
                end
                m_field = 0;
            end
        endcase
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input string name, input int kind, input logic [7:0] a,
                             input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event kind=%0d a=%h d=%h, expected none", name, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.d != d) begin
                errors++;
                $display("FAIL %s: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                         name, kind, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor
    always @(negedge CLK) begin
        if (!RESET) begin
            if (PKT_OK && PKT_ERR) begin
                checks++; errors++;
                $display("FAIL ok_err_overlap: got PKT_OK=1 PKT_ERR=1, expected not both");
            end
            if (RX_FIFO_RD_REQ) chk("rd_req_single_cycle", rd_prev, 0);
            if (REG_WR_STB) expect_ev("reg_write", 0, REG_ADDR, REG_DATA);
            if (PKT_OK)     expect_ev("pkt_ok", 1, 8'h00, 8'h00);
            if (PKT_ERR) begin
                expect_ev("pkt_err", 2, 8'h00, {6'b0, ERR_CODE});
                if (ERR_CODE == 2'd3) begin
                    checks++;
                    if (cyc - last_rd_cyc < TO || cyc - last_rd_cyc > TO + 8) begin
                        errors++;
                        $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d",
                                 cyc - last_rd_cyc, TO, TO + 8);
                    end
                end
            end
        end
        rd_prev <= RX_FIFO_RD_REQ;
    end

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        fifo.push_back(b);
        pushed++;
        @(negedge CLK);
        repeat ($urandom_range(0, 6)) @(negedge CLK);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (fifo.size() != 0 && n < 5000) begin @(negedge CLK); n++; end
        if (fifo.size() != 0) begin
            checks++; errors++;
            $display("FAIL fifo_drain: got %0d bytes left, expected 0", fifo.size());
        end
    endtask

    task automatic settle();
        wait_empty();
        repeat (40) @(negedge CLK);
    endtask

    // Let the link go quiet long enough for any partial frame to time out
    task automatic drain_timeout();
        wait_empty();
        repeat (10) @(negedge CLK);
        if (m_field != 0) begin
            chk("busy_mid_frame", BUSY, 1);
            push_ev(2, 0, 3);
            m_field = 0;
        end
        repeat (2 * TO) @(negedge CLK);
    endtask

    task automatic send_frame(input int base, input int len, input bit corrupt);
        logic [7:0] bs[$];
        int s;
        bs.push_back(8'hA5);
        bs.push_back(8'(base));
        bs.push_back(8'(len));
        s = base + len;
        for (int i = 0; i < len; i++) begin
            bs.push_back(8'($urandom_range(0, 255)));
            s += int'(bs[$]);
        end
        if (corrupt) s += $urandom_range(1, 255);
        bs.push_back(8'(s));
        send_bytes(bs);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_req"}, RX_FIFO_RD_REQ, 0);
        chk({tag, "_wr_stb"}, REG_WR_STB, 0);
        chk({tag, "_addr"}, REG_ADDR, 0);
        chk({tag, "_data"}, REG_DATA, 0);
        chk({tag, "_ok"}, PKT_OK, 0);
        chk({tag, "_err"}, PKT_ERR, 0);
        chk({tag, "_err_code"}, ERR_CODE, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int n;
        int r;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RESET = 1'b0;
        @(negedge CLK);

        // Valid two-byte frame
        rc0 = rd_count;
        send_bytes('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45});
        settle();
        chk("valid_rd_pulses", rd_count - rc0, 6);
        chk("valid_err_code", ERR_CODE, 0);

        // Junk ahead of a frame
        send_bytes('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h20, 8'h01, 8'h7E, 8'h9F});
        settle();

        // Bad checksum, then a good frame
        send_bytes('{8'hA5, 8'h10, 8'h01, 8'h33, 8'h00});
        send_bytes('{8'hA5, 8'h30, 8'h01, 8'h55, 8'h86});
        settle();

        // Bad lengths, then resync on a good frame
        send_bytes('{8'hA5, 8'h10, 8'h00});
        send_bytes('{8'hA5, 8'h10, 8'h11});
        send_bytes('{8'hA5, 8'h40, 8'h01, 8'h01, 8'h42});
        settle();
        chk("badlen_err_code_hold", ERR_CODE, 1);

        // Timeout mid-frame, then an address-wrapping frame
        send_bytes('{8'hA5, 8'hFE});
        drain_timeout();
        chk("timeout_err_code", ERR_CODE, 3);
        send_bytes('{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h04});
        settle();
        chk("err_code_holds", ERR_CODE, 3);

        // Reset during the second write of a four-byte commit
        send_bytes('{8'hA5, 8'h50, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5E});
        n = 0;
        while (!REG_WR_STB && n < 500) begin @(negedge CLK); n++; end
        chk("commit_started", REG_WR_STB, 1);
        @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        check_idle_outputs("reset_commit");
        chk("pending_after_reset", exp_q.size(), 4);
        exp_q.delete();
        m_field = 0;
        repeat (2) @(negedge CLK);
        chk("no_write_in_reset", REG_WR_STB, 0);
        RESET = 1'b0;
        @(negedge CLK);
        send_bytes('{8'hA5, 8'h60, 8'h02, 8'h0A, 8'h0B, 8'h77});
        settle();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(0, 255)));
            end else if (r <= 6) begin
                send_frame($urandom_range(0, 255), $urandom_range(1, MAX_LEN), 1'b0);
            end else if (r == 7) begin
                send_frame($urandom_range(0, 255), $urandom_range(1, MAX_LEN), 1'b1);
            end else if (r == 8) begin
                send_byte(8'hA5);
                send_byte(8'($urandom_range(0, 255)));
                send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                send_byte(8'hA5);
                send_byte(8'($urandom_range(0, 255)));
                send_byte(8'($urandom_range(2, MAX_LEN)));
                send_byte(8'($urandom_range(0, 255)));
                drain_timeout();
            end
        end
        drain_timeout();
        settle();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("fifo_overread", overread, 0);
        chk("rd_pulses_total", rd_count, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
